// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned OPW = 4;
  localparam int unsigned PW  = 8;

  // Width of a counter that must be able to hold the value tmo.
  function automatic int unsigned wd_width(input int unsigned tmo);
    return $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int unsigned j;
    j      = 0;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      j = 32'(ptr) + 32'(k);
      if (j >= NREQ) j = j - NREQ;
      if (req[IW'(j)]) begin
        valid            = 1'b1;
        idx              = IW'(j);
        onehot           = '0;
        onehot[IW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one start/ready multiplier between NREQ clients.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [OPW*NREQ-1:0]  a_in,
  input  logic [OPW*NREQ-1:0]  b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [PW-1:0]        result,
  output logic                 busy,
  output logic                 err,
  output logic                 mul_start,
  output logic [OPW-1:0]       mul_word1,
  output logic [OPW-1:0]       mul_word2,
  input  logic [PW-1:0]        mul_product,
  input  logic                 mul_ready
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned WW = wd_width(TMO);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n, ptr, ptr_n, ptr_inc;
  logic [WW-1:0]   wcnt, wcnt_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic [PW-1:0]   result_n;
  logic            busy_n, err_n, start_n;
  logic [OPW-1:0]  word1_n, word2_n;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic [OPW-1:0]  a_arr [NREQ];
  logic [OPW-1:0]  b_arr [NREQ];

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Split the flat operand buses into per-requester words.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = a_in[i*OPW +: OPW];
      b_arr[i] = b_in[i*OPW +: OPW];
    end
  end

  // Priority moves to the requester just after the one being served.
  assign ptr_inc = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    ptr_n    = ptr;
    wcnt_n   = wcnt;
    gnt_n    = '0;
    done_n   = '0;
    result_n = result;
    err_n    = err;
    start_n  = 1'b0;
    word1_n  = mul_word1;
    word2_n  = mul_word2;
    unique case (state)
      IDLE: begin
        if (pick_valid && mul_ready) begin
          state_n = ISSUE;
          idx_n   = pick_idx;
          gnt_n   = pick_onehot;
          start_n = 1'b1;
          word1_n = a_arr[pick_idx];
          word2_n = b_arr[pick_idx];
        end
      end
      ISSUE: begin
        state_n = WAIT;
        wcnt_n  = '0;
      end
      WAIT: begin
        if (mul_ready) begin
          state_n     = RESP;
          result_n    = mul_product;
          ptr_n       = ptr_inc;
          done_n[idx] = 1'b1;
        end else if (wcnt == WW'(TMO - 1)) begin
          state_n     = RESP;
          result_n    = '0;
          err_n       = 1'b1;
          ptr_n       = ptr_inc;
          done_n[idx] = 1'b1;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      RESP: begin
        state_n = IDLE;
        wcnt_n  = '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      ptr       <= '0;
      wcnt      <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      mul_word1 <= '0;
      mul_word2 <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      ptr       <= ptr_n;
      wcnt      <= wcnt_n;
      gnt       <= gnt_n;
      done      <= done_n;
      result    <= result_n;
      busy      <= busy_n;
      err       <= err_n;
      mul_start <= start_n;
      mul_word1 <= word1_n;
      mul_word2 <= word2_n;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a cycle-accurate multiplier model.
module tb_mul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 12;

  typedef struct {
    int         idx;
    logic [7:0] res;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        result;
  logic              busy, err, mul_start;
  logic [3:0]        mul_word1, mul_word2;
  logic [7:0]        mul_product;
  logic              mul_ready;

  logic              stuck;
  logic [3:0]        ma, mb, mcnt;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  mul_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .a_in        (a_in),
    .b_in        (b_in),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .busy        (busy),
    .err         (err),
    .mul_start   (mul_start),
    .mul_word1   (mul_word1),
    .mul_word2   (mul_word2),
    .mul_product (mul_product),
    .mul_ready   (mul_ready)
  );

  always #5 clk = ~clk;

  // Multiplier model: busy for 4 + popcount(b) cycles after a start; stuck freezes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
      mcnt        <= '0;
      ma          <= '0;
      mb          <= '0;
    end else if (mul_start && mul_ready) begin
      mul_ready <= 1'b0;
      mcnt      <= 4'(4 + $countones(mul_word2));
      ma        <= mul_word1;
      mb        <= mul_word2;
    end else if (!mul_ready && !stuck) begin
      if (mcnt == 4'd1) begin
        mul_ready   <= 1'b1;
        mul_product <= 8'(ma) * 8'(mb);
      end
      mcnt <= mcnt - 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = 1;
    return v << i;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    32'(gnt),       32'd0);
    check({tag, "_done"},   32'(done),      32'd0);
    check({tag, "_result"}, 32'(result),    32'd0);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_err"},    32'(err),       32'd0);
    check({tag, "_start"},  32'(mul_start), 32'd0);
    check({tag, "_w1"},     32'(mul_word1), 32'd0);
    check({tag, "_w2"},     32'(mul_word2), 32'd0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    req   = '0;
    reset = 1'b1;
    #1;
    check_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic pop_cmp(input logic [NREQ-1:0] d);
    exp_t e;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("done_vec", 32'(d), 32'(oh(e.idx)));
      check("result", 32'(result), 32'(e.res));
    end
  endtask

  task automatic wait_done(output logic [NREQ-1:0] d);
    d = '0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (done != '0) begin
        d = done;
        break;
      end
    end
    check("done_seen", 32'(d != '0), 32'd1);
  endtask

  // One isolated operation; returns in the RESP cycle with req dropped.
  task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b);
    exp_t       e;
    int         lat;
    logic       seen;
    lat   = stuck ? 2 + int'(TMO) : 7 + $countones(b);
    e.idx = r;
    e.res = stuck ? 8'd0 : 8'(a) * 8'(b);
    @(posedge clk); #1;
    a_in[r*4 +: 4] = a;
    b_in[r*4 +: 4] = b;
    req[r]         = 1'b1;
    sb.push_back(e);
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        check("gnt", 32'(gnt), 32'(oh(r)));
        check("mul_start", 32'(mul_start), 32'd1);
        check("mul_word1", 32'(mul_word1), 32'(a));
        check("mul_word2", 32'(mul_word2), 32'(b));
        check("busy", 32'(busy), 32'd1);
      end
      if (n == 2) begin
        check("gnt_1cyc", 32'(gnt), 32'd0);
        check("start_1cyc", 32'(mul_start), 32'd0);
      end
      if (done != '0) begin
        seen = 1'b1;
        check("latency", 32'(n), 32'(lat));
        pop_cmp(done);
        req[r] = 1'b0;
      end
    end
    check("op_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] d;
    logic [3:0] av [NREQ];
    logic [3:0] bv [NREQ];
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1'b0;

    // Basic product and boundary latencies.
    run_op(0, 4'd13, 4'd11);
    check("err_clean", 32'(err), 32'd0);
    run_op(0, 4'd15, 4'd0);
    run_op(1, 4'd15, 4'd15);

    // All four requesting from a fresh pointer: served 0,1,2,3.
    reset_dut();
    av = '{4'd3, 4'd5, 4'd9, 4'd14};
    bv = '{4'd7, 4'd2, 4'd15, 4'd1};
    @(posedge clk); #1;
    for (int i = 0; i < int'(NREQ); i++) begin
      exp_t e;
      a_in[i*4 +: 4] = av[i];
      b_in[i*4 +: 4] = bv[i];
      e.idx = i;
      e.res = 8'(av[i]) * 8'(bv[i]);
      sb.push_back(e);
    end
    req = '1;
    for (int k = 0; k < int'(NREQ); k++) begin
      wait_done(d);
      pop_cmp(d);
      req = req & ~d;
    end

    // req[2] held, req[1] arrives mid-WAIT: 2, then 1, then 2 again.
    @(posedge clk); #1;
    a_in[8 +: 4] = 4'd6;  b_in[8 +: 4] = 4'd10;
    a_in[4 +: 4] = 4'd11; b_in[4 +: 4] = 4'd12;
    req[2] = 1'b1;
    sb.push_back('{idx: 2, res: 8'd60});
    repeat (3) begin @(posedge clk); #1; end
    req[1] = 1'b1;
    sb.push_back('{idx: 1, res: 8'd132});
    sb.push_back('{idx: 2, res: 8'd60});
    for (int k = 0; k < 3; k++) begin
      wait_done(d);
      pop_cmp(d);
      if (k > 0) req = req & ~d;
    end

    // Reset during WAIT: outputs clear at once, no done, then normal service.
    @(posedge clk); #1;
    a_in[0 +: 4] = 4'd7; b_in[0 +: 4] = 4'd9;
    req[0] = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("busy_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_zero("mid");
    @(posedge clk); #1;
    req   = '0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run_op(0, 4'd7, 4'd9);

    // Stuck multiplier: watchdog abort with sticky err.
    stuck = 1'b1;
    run_op(3, 4'd5, 4'd5);
    check("err_set", 32'(err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("err_sticky", 32'(err), 32'd1);
    end
    stuck = 1'b0;
    reset_dut();
    run_op(2, 4'd9, 4'd8);
    check("err_after_rst", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
